// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single display-RAM port between the VGA pixel
// fetcher (strict priority, never stalled) and the CR16 CPU (served in idle
// slots). A tag pipeline steers returning read data back to its requester.
module vram_arbiter #(
   parameter int unsigned AW       = 13,
   parameter int unsigned DW       = 16,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned MAX_WAIT = 800
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          vga_req,
   input  logic [AW-1:0] vga_addr,
   output logic [DW-1:0] vga_data,
   output logic          vga_valid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_starved,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RD, C_ACK} cstate_t;

   cstate_t         r_state;
   logic            r_cpu_we;
   logic [AW-1:0]   r_cpu_addr;
   logic [DW-1:0]   r_cpu_wdata;
   logic [15:0]     r_wait;
   logic [RD_LAT:0] r_tag_v;
   logic [RD_LAT:0] r_tag_cpu;

   logic w_cpu_grant;
   logic w_cpu_rd;
   logic w_issue_rd;
   logic w_out_vga;
   logic w_out_cpu;

   // CPU owns the slot only when it is waiting and VGA is silent this cycle
   assign w_cpu_grant = (r_state == C_WAIT) && !vga_req;
   assign w_cpu_rd    = w_cpu_grant && !r_cpu_we;
   assign w_issue_rd  = vga_req || w_cpu_rd;
   assign w_out_vga   = r_tag_v[RD_LAT] && !r_tag_cpu[RD_LAT];
   assign w_out_cpu   = r_tag_v[RD_LAT] &&  r_tag_cpu[RD_LAT];

   // RAM slot register: VGA first, then a waiting CPU; idle slots hold the address and never write
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else if (vga_req) begin
         mem_addr  <= vga_addr;
         mem_we    <= 1'b0;
      end else if (w_cpu_grant) begin
         mem_addr  <= r_cpu_addr;
         mem_we    <= r_cpu_we;
         mem_wdata <= r_cpu_wdata;
      end else begin
         mem_we    <= 1'b0;
      end
   end

   // Tag pipe: {valid, owner} travels alongside each read for RD_LAT+1 stages
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_tag_v   <= '0;
         r_tag_cpu <= '0;
      end else begin
         r_tag_v   <= {r_tag_v[RD_LAT-1:0], w_issue_rd};
         r_tag_cpu <= {r_tag_cpu[RD_LAT-1:0], w_cpu_rd};
      end
   end

   // VGA return path: capture RAM data when the output-stage tag belongs to VGA
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         vga_valid <= 1'b0;
         vga_data  <= '0;
      end else begin
         vga_valid <= w_out_vga;
         if (w_out_vga) begin
            vga_data <= mem_rdata;
         end
      end
   end

   // CPU FSM with registered ack/rdata, saturating wait counter and sticky starvation flag
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state     <= C_IDLE;
         r_cpu_we    <= 1'b0;
         r_cpu_addr  <= '0;
         r_cpu_wdata <= '0;
         r_wait      <= '0;
         cpu_ack     <= 1'b0;
         cpu_rdata   <= '0;
         cpu_starved <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         case (r_state)
            C_IDLE: begin
               if (cpu_req) begin
                  r_cpu_we    <= cpu_we;
                  r_cpu_addr  <= cpu_addr;
                  r_cpu_wdata <= cpu_wdata;
                  r_state     <= C_WAIT;
               end
            end
            C_WAIT: begin
               if (!vga_req) begin
                  r_wait <= '0;
                  if (r_cpu_we) begin
                     cpu_ack <= 1'b1;
                     r_state <= C_ACK;
                  end else begin
                     r_state <= C_RD;
                  end
               end else begin
                  if (r_wait != '1) begin
                     r_wait <= r_wait + 16'd1;
                  end
                  // r_wait+1 > MAX_WAIT, written without widening the counter
                  if (32'(r_wait) >= MAX_WAIT) begin
                     cpu_starved <= 1'b1;
                  end
               end
            end
            C_RD: begin
               if (w_out_cpu) begin
                  cpu_ack   <= 1'b1;
                  cpu_rdata <= mem_rdata;
                  r_state   <= C_ACK;
               end
            end
            C_ACK: begin
               r_state <= C_IDLE;
            end
            default: r_state <= C_IDLE;
         endcase
      end
   end

endmodule
